// File: rtl/pipeline_hazard_controller_if.sv
// Hazard controller port bundle: pipeline-side status in, stage enables,
// flushes, refill strobes and performance counters out.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic             memAccess;
  logic             cacheHit;
  logic             memReady;
  logic             branchTaken;
  logic             idExMemRead;
  logic [4:0]       idExWriteReg;
  logic [4:0]       ifIdRs;
  logic [4:0]       ifIdRt;
  logic             pipeEn;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             idExBubble;
  logic             flushIfId;
  logic             flushIdEx;
  logic             flushExMem;
  logic             refillReq;
  logic             refillWe;
  logic [CNT_W-1:0] missCount;
  logic [CNT_W-1:0] stallCycles;

  modport master (
    output memAccess, cacheHit, memReady, branchTaken,
    output idExMemRead, idExWriteReg, ifIdRs, ifIdRt,
    input  pipeEn, pcWrite, ifIdWrite, idExBubble,
    input  flushIfId, flushIdEx, flushExMem,
    input  refillReq, refillWe, missCount, stallCycles
  );

  modport slave (
    input  memAccess, cacheHit, memReady, branchTaken,
    input  idExMemRead, idExWriteReg, ifIdRs, ifIdRt,
    output pipeEn, pcWrite, ifIdWrite, idExBubble,
    output flushIfId, flushIdEx, flushExMem,
    output refillReq, refillWe, missCount, stallCycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: common stage enable, D-cache miss/refill FSM,
// load-use bubble and MEM-stage branch flush.
module pipeline_hazard_controller #(
  parameter int REFILL_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input logic CLK,
  input logic RST_n,
  pipeline_hazard_controller_if.slave hz
);
  typedef enum logic [1:0] {
    RUN,
    MISS_REQ,
    MISS_WAIT,
    REFILL
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [CNT_W-1:0] miss_cnt, stall_cnt;
  logic             miss, pipe_en, load_use;
  logic             sel_stall, sel_br, sel_lu;

  assign miss = hz.memAccess & ~hz.cacheHit;
  assign pipe_en = (state == RUN) & ~miss;

  assign load_use = hz.idExMemRead
                  & (hz.idExWriteReg != 5'd0)
                  & ((hz.idExWriteReg == hz.ifIdRs)
                   | (hz.idExWriteReg == hz.ifIdRt));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= RUN;
      cnt       <= 4'd0;
      miss_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == RUN && miss && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
      if (!pipe_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (miss)
          state_nx = MISS_REQ;
      end
      MISS_REQ: begin
        state_nx = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (hz.memReady) begin
          state_nx = REFILL;
          cnt_nx   = 4'(REFILL_CYCLES - 1);
        end
      end
      REFILL: begin
        if (cnt == 4'd0)
          state_nx = RUN;
        else
          cnt_nx = cnt - 4'd1;
      end
      default: state_nx = RUN;
    endcase
  end

  // Mutually exclusive selects so the priority chain can be a unique case
  assign sel_stall = ~pipe_en;
  assign sel_br    = pipe_en & hz.branchTaken;
  assign sel_lu    = pipe_en & ~hz.branchTaken & load_use;

  always_comb begin
    hz.pcWrite    = 1'b1;
    hz.ifIdWrite  = 1'b1;
    hz.idExBubble = 1'b0;
    hz.flushIfId  = 1'b0;
    hz.flushIdEx  = 1'b0;
    hz.flushExMem = 1'b0;
    unique case (1'b1)
      sel_stall: begin
        hz.pcWrite   = 1'b0;
        hz.ifIdWrite = 1'b0;
      end
      sel_br: begin
        hz.flushIfId  = 1'b1;
        hz.flushIdEx  = 1'b1;
        hz.flushExMem = 1'b1;
      end
      sel_lu: begin
        hz.pcWrite    = 1'b0;
        hz.ifIdWrite  = 1'b0;
        hz.idExBubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.pipeEn      = pipe_en;
  assign hz.refillReq   = (state == MISS_REQ);
  assign hz.refillWe    = (state == REFILL);
  assign hz.missCount   = miss_cnt;
  assign hz.stallCycles = stall_cnt;
endmodule
